// File: rtl/mem_lane_unit.sv
// MEM-stage data-memory access unit: store-data forwarding, lane byte enables,
// request/ack handshake to data memory and two-beat handling of misaligned accesses.
module mem_lane_unit #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned NUM_FWD        = 3,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [3:0]                       mem_op,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                rt_data,
  input  logic [NUM_FWD*DATA_W-1:0]        fwd_data,
  input  logic [$clog2(NUM_FWD+1)-1:0]     fwd_sel,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W/8-1:0]              mem_be,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_W-1:0]                mem_rdata,
  output logic                             resp_valid,
  output logic [DATA_W-1:0]                load_data,
  output logic                             misalign_exc
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = OW + 2;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_op;
  logic [OW-1:0]     r_off;
  logic              r_split;
  logic [NB-1:0]     r_be1;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W-1:0] w_sdata;
  logic [DATA_W-1:0] w_rot;
  logic [OW-1:0]     w_off;
  logic [CW-1:0]     w_n;
  logic [CW-1:0]     w_end;
  logic              w_exc;
  logic              w_split;
  logic [NB-1:0]     w_be0;
  logic [NB-1:0]     w_be1;
  logic [ADDR_W-1:0] w_base;
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_ext;
  logic [CW-1:0]     w_rn;
  logic              w_sign;

  // Store-data source select; unmatched selects yield zero data.
  always_comb begin
    w_sdata = '0;
    if (fwd_sel == '0) w_sdata = rt_data;
    for (int k = 0; k < int'(NUM_FWD); k++)
      if (int'(fwd_sel) == k + 1) w_sdata = fwd_data[k*DATA_W +: DATA_W];
  end

  // Request decode: lane offset, span, byte enables and rotated store data.
  always_comb begin
    w_off   = addr[OW-1:0];
    w_base  = {addr[ADDR_W-1:OW], OW'(0)};
    w_n     = CW'(1) << mem_op[1:0];
    w_end   = CW'(w_off) + w_n;
    w_split = (w_end > CW'(NB));
    w_exc   = (w_n > CW'(NB)) ||
              (!MISALIGN_SPLIT && ((w_off & OW'(w_n - CW'(1))) != '0));
    for (int i = 0; i < int'(NB); i++) begin
      w_be0[i] = (CW'(i) >= CW'(w_off)) && (CW'(i) < w_end);
      w_be1[i] = (CW'(i + int'(NB)) < w_end);
    end
    w_rot = DATA_W'(({w_sdata, w_sdata} << {w_off, 3'b000}) >> DATA_W);
  end

  // Load merge of one or two beats, then sign/zero extension above the access size.
  always_comb begin
    w_lo   = (r_state == S_BEAT1) ? r_lo : mem_rdata;
    w_raw  = DATA_W'({mem_rdata, w_lo} >> {r_off, 3'b000});
    w_rn   = CW'(1) << r_op[1:0];
    w_sign = 1'b0;
    for (int j = 0; j < int'(NB); j++)
      if (CW'(j + 1) == w_rn) w_sign = w_raw[8*j+7];
    if (r_op[2]) w_sign = 1'b0;
    for (int j = 0; j < int'(NB); j++)
      w_ext[8*j +: 8] = (CW'(j) < w_rn) ? w_raw[8*j +: 8] : {8{w_sign}};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_off        <= '0;
      r_split      <= 1'b0;
      r_be1        <= '0;
      r_base       <= '0;
      r_lo         <= '0;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      resp_valid   <= 1'b0;
      load_data    <= '0;
      misalign_exc <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op      <= mem_op;
            r_off     <= w_off;
            r_split   <= w_split;
            r_be1     <= w_be1;
            r_base    <= w_base;
            req_ready <= 1'b0;
            if (w_exc) begin
              r_state      <= S_RESP;
              resp_valid   <= 1'b1;
              misalign_exc <= 1'b1;
              load_data    <= '0;
            end else begin
              r_state   <= S_BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= mem_op[3];
              mem_addr  <= w_base;
              mem_be    <= w_be0;
              mem_wdata <= w_rot;
            end
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (mem_ack) begin
            if (r_state == S_BEAT0 && r_split) begin
              r_state  <= S_BEAT1;
              r_lo     <= mem_rdata;
              mem_addr <= r_base + ADDR_W'(NB);
              mem_be   <= r_be1;
            end else begin
              r_state    <= S_RESP;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              mem_addr   <= '0;
              mem_be     <= '0;
              mem_wdata  <= '0;
              resp_valid <= 1'b1;
              load_data  <= r_op[3] ? '0 : w_ext;
            end
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          req_ready    <= 1'b1;
          misalign_exc <= 1'b0;
          load_data    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lane_unit.sv
// Bench for mem_lane_unit: byte-addressed memory model acts as data memory and
// predicts beats, byte enables, store contents, load results and latency.
module tb_mem_lane_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           rv_a, rv_b;
  logic [3:0]     op;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  rt;
  logic [NF*DW-1:0] fwd;
  logic [1:0]     sel;
  logic           mem_ack;
  logic [DW-1:0]  mem_rdata;

  logic           rdy_a, req_a, we_a, resp_a, exc_a;
  logic [AW-1:0]  ma_a;
  logic [3:0]     be_a;
  logic [DW-1:0]  wd_a, ld_a;
  logic           rdy_b, req_b, we_b, resp_b, exc_b;
  logic [AW-1:0]  ma_b;
  logic [3:0]     be_b;
  logic [DW-1:0]  wd_b, ld_b;

  mem_lane_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .MISALIGN_SPLIT(1'b1)) u_split (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a), .mem_op(op), .addr(addr),
    .rt_data(rt), .fwd_data(fwd), .fwd_sel(sel), .mem_req(req_a), .mem_we(we_a),
    .mem_addr(ma_a), .mem_be(be_a), .mem_wdata(wd_a), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_a), .load_data(ld_a), .misalign_exc(exc_a));

  mem_lane_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .MISALIGN_SPLIT(1'b0)) u_nosplit (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b), .mem_op(op), .addr(addr),
    .rt_data(rt), .fwd_data(fwd), .fwd_sel(sel), .mem_req(req_b), .mem_we(we_b),
    .mem_addr(ma_b), .mem_be(be_b), .mem_wdata(wd_b), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_b), .load_data(ld_b), .misalign_exc(exc_b));

  logic           cur_b;
  logic           o_rdy, o_req, o_we, o_resp, o_exc;
  logic [AW-1:0]  o_ma;
  logic [3:0]     o_be;
  logic [DW-1:0]  o_wd, o_ld;
  assign o_rdy  = cur_b ? rdy_b  : rdy_a;
  assign o_req  = cur_b ? req_b  : req_a;
  assign o_we   = cur_b ? we_b   : we_a;
  assign o_resp = cur_b ? resp_b : resp_a;
  assign o_exc  = cur_b ? exc_b  : exc_a;
  assign o_ma   = cur_b ? ma_b   : ma_a;
  assign o_be   = cur_b ? be_b   : be_a;
  assign o_wd   = cur_b ? wd_b   : wd_a;
  assign o_ld   = cur_b ? ld_b   : ld_a;

  logic [7:0] phys [256];
  logic [7:0] mdl  [256];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    phys[8'(a)] = b;
    mdl[8'(a)]  = b;
  endtask

  // One complete transaction; the bench plays data memory with random ack waits.
  task automatic run_op(input bit use_b, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s, input int unsigned max_wait);
    int n, off, nbeats, cyc, beat, waits, left, rel;
    bit exc, done, seen;
    logic [31:0] exp_ld, exp_wd, mask, exp_ma, stored, exp_st;
    logic [3:0]  exp_be;
    logic [95:0] fv;

    n      = 1 << int'(o[1:0]);
    off    = int'(a[1:0]);
    exc    = (n > 4) || (use_b && (off % n != 0));
    nbeats = exc ? 0 : ((off + n > 4) ? 2 : 1);
    exp_ld = '0;
    if (!exc) begin
      for (int j = 0; j < n; j++) exp_ld[8*j +: 8] = mdl[8'(a + 32'(j))];
      if (!o[2] && n < 4 && exp_ld[8*n-1])
        for (int j = n; j < 4; j++) exp_ld[8*j +: 8] = 8'hFF;
    end

    fv = {$urandom, $urandom, $urandom};
    if (s != 2'd0) fv[(int'(s)-1)*32 +: 32] = d;
    @(negedge clk);
    cur_b = use_b;
    rv_a  = !use_b;
    rv_b  = use_b;
    op    = o;
    addr  = a;
    rt    = (s == 2'd0) ? d : $urandom;
    fwd   = fv;
    sel   = s;
    chk("rdy_idle", 64'(o_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rv_a = 1'b0;
    rv_b = 1'b0;
    rt   = $urandom;
    fwd  = {$urandom, $urandom, $urandom};
    sel  = 2'($urandom);

    cyc = 1; beat = 0; waits = 0; done = 0; seen = 0;
    left = int'($urandom_range(max_wait));
    while (!done && cyc < 40) begin
      mem_ack = 1'b0;
      if (o_resp) begin
        done = 1;
        chk("latency", 64'(cyc), 64'(exc ? 1 : 1 + nbeats + waits));
        chk("beats", 64'(beat), 64'(nbeats));
        chk("exc", 64'(o_exc), 64'(exc));
        chk("req_in_resp", 64'(o_req), 64'd0);
        chk("rdy_in_resp", 64'(o_rdy), 64'd0);
        if (!o[3] || exc) chk("load_data", 64'(o_ld), 64'(exp_ld));
      end else begin
        chk("rdy_busy", 64'(o_rdy), 64'd0);
        if (!o_req) chk("req_missing", 64'(o_req), 64'd1);
        else begin
          exp_ma = (a & 32'hFFFF_FFFC) + 32'(4 * beat);
          if (!seen) begin
            seen = 1;
            exp_be = '0; exp_wd = '0; mask = '0;
            for (int i = 0; i < 4; i++) begin
              rel = 4 * beat + i - off;
              if (rel >= 0 && rel < n) begin
                exp_be[i] = 1'b1;
                exp_wd[8*i +: 8] = d[8*rel +: 8];
                mask[8*i +: 8] = 8'hFF;
              end
            end
            if (beat >= nbeats) chk("extra_beat", 64'(beat), 64'(nbeats));
            chk("beat_addr", 64'(o_ma), 64'(exp_ma));
            chk("beat_be", 64'(o_be), 64'(exp_be));
            chk("beat_we", 64'(o_we), 64'(o[3]));
            chk("beat_wdata", 64'(o_wd & mask), 64'(exp_wd));
          end
          if (left > 0) begin
            left--;
            waits++;
          end else begin
            mem_ack = 1'b1;
            for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = phys[8'(exp_ma + 32'(i))];
            if (o[3])
              for (int i = 0; i < 4; i++)
                if (o_be[i]) phys[8'(exp_ma + 32'(i))] = o_wd[8*i +: 8];
            beat++;
            seen = 0;
            left = int'($urandom_range(max_wait));
          end
        end
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    if (!done) chk("timeout", 64'd0, 64'd1);

    if (o[3] && !exc) begin
      stored = '0; exp_st = '0;
      for (int j = 0; j < n; j++) begin
        mdl[8'(a + 32'(j))] = d[8*j +: 8];
        stored[8*j +: 8] = phys[8'(a + 32'(j))];
        exp_st[8*j +: 8] = d[8*j +: 8];
      end
      chk("store_mem", 64'(stored), 64'(exp_st));
    end
  endtask

  initial begin
    reset = 1'b0; rv_a = 1'b0; rv_b = 1'b0; cur_b = 1'b0;
    op = '0; addr = '0; rt = '0; fwd = '0; sel = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      phys[i] = 8'($urandom);
      mdl[i]  = phys[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_ready", 64'(rdy_a), 64'd1);
    chk("rst_req", 64'(req_a), 64'd0);
    chk("rst_resp", 64'(resp_a), 64'd0);
    chk("rst_exc", 64'(exc_a), 64'd0);
    chk("rst_be", 64'(be_a), 64'd0);
    chk("rst_load", 64'(ld_a), 64'd0);

    run_op(1'b0, 4'b1010, 32'h0000_1004, 32'hDEAD_BEEF, 2'd0, 0);
    run_op(1'b0, 4'b1000, 32'h0000_1003, 32'h0000_00A5, 2'd2, 0);
    poke(32'h2000, 8'h34); poke(32'h2001, 8'h12); poke(32'h2002, 8'h01); poke(32'h2003, 8'h80);
    run_op(1'b0, 4'b0001, 32'h0000_2002, 32'h0, 2'd0, 0);
    chk("lh_value", 64'(ld_a), 64'h0000_0000_FFFF_8001);
    run_op(1'b0, 4'b0101, 32'h0000_2002, 32'h0, 2'd0, 0);
    chk("lhu_value", 64'(ld_a), 64'h0000_0000_0000_8001);
    poke(32'h3003, 8'h11); poke(32'h3004, 8'h22); poke(32'h3005, 8'h33); poke(32'h3006, 8'h44);
    run_op(1'b0, 4'b0010, 32'h0000_3003, 32'h0, 2'd0, 0);
    chk("lw_split_value", 64'(ld_a), 64'h0000_0000_4433_2211);
    run_op(1'b1, 4'b1001, 32'h0000_0001, 32'h0000_BEEF, 2'd0, 0);
    run_op(1'b1, 4'b0011, 32'h0000_0000, 32'h0, 2'd0, 0);
    run_op(1'b0, 4'b0011, 32'h0000_0008, 32'h0, 2'd0, 0);

    for (int t = 0; t < 200; t++)
      run_op(($urandom_range(3) == 0), 4'($urandom), $urandom, $urandom, 2'($urandom), 2);

    // Reset while a beat waits for ack: beat dropped, late ack ignored.
    @(negedge clk);
    cur_b = 1'b0; rv_a = 1'b1; op = 4'b1010; addr = 32'h40; rt = 32'h1234_5678; sel = 2'd0;
    @(posedge clk);
    @(negedge clk);
    rv_a = 1'b0; mem_ack = 1'b0;
    chk("t6_req", 64'(o_req), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("t6_req_after", 64'(o_req), 64'd0);
    chk("t6_rdy", 64'(o_rdy), 64'd1);
    chk("t6_resp", 64'(o_resp), 64'd0);
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t6_late_resp", 64'(o_resp), 64'd0);
    chk("t6_late_req", 64'(o_req), 64'd0);
    chk("t6_late_rdy", 64'(o_rdy), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
